// File: rtl/seq_signed_shift_add_multiplier_if.sv
// Handshake/bus bundle for seq_signed_shift_add_multiplier.
// Signal names are from the multiplier's point of view:
//   i_start        request, sampled only while the multiplier is idle
//   i_signed_mode  1 = operands are two's complement, 0 = unsigned
//   i_a            multiplier operand (scanned LSB first)
//   i_b            multiplicand operand
//   o_busy         operation in progress (RUN or DONE)
//   o_done         one-cycle pulse, o_product valid on the same cycle
//   o_product      2*WIDTH-bit result, held until the next accepted start
// master = controller side, slave = multiplier side.
interface seq_signed_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 i_start;
  logic                 i_signed_mode;
  logic [WIDTH-1:0]     i_a;
  logic [WIDTH-1:0]     i_b;
  logic                 o_busy;
  logic                 o_done;
  logic [2*WIDTH-1:0]   o_product;

  modport master (
    output i_start, i_signed_mode, i_a, i_b,
    input  o_busy, o_done, o_product
  );

  modport slave (
    input  i_start, i_signed_mode, i_a, i_b,
    output o_busy, o_done, o_product
  );
endinterface

// File: rtl/seq_signed_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, with
// runtime signed/unsigned selection.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (aborts any operation, no done)
//   bus  slave side of seq_signed_shift_add_multiplier_if (start/busy/done,
//        operands, product)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; product holds the last result
// RUN    | WIDTH cycles accumulating partial products, one extra cycle to
//        | hand the accumulator over
// DONE   | done pulse, product valid; returns to IDLE on the next edge
module seq_signed_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input logic                          clk,
  input logic                          rst,
  seq_signed_shift_add_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_signed;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [PW-1:0]    r_product;

  logic [PW-1:0]    w_b_ext;
  logic             w_msb_step;
  logic             w_subtract;
  logic [PW-1:0]    w_acc_next;

  // Multiplicand widened once at acceptance; sign bit replicated only in
  // signed mode.
  assign w_b_ext = {{WIDTH{bus.i_signed_mode & bus.i_b[WIDTH-1]}}, bus.i_b};

  // The multiplier MSB carries weight -2^(WIDTH-1) in two's complement, so
  // its partial product is subtracted instead of added.
  assign w_msb_step = (r_count == CW'(WIDTH - 1));
  assign w_subtract = r_signed & w_msb_step;

  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      if (w_subtract) w_acc_next = r_acc - r_mcand;
      else            w_acc_next = r_acc + r_mcand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_signed  <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_mplier <= bus.i_a;
            r_mcand  <= w_b_ext;
            r_signed <= bus.i_signed_mode;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          if (r_count == CW'(WIDTH)) begin
            r_product <= r_acc;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            // Multiplier shifts right so the current bit is always bit 0.
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_product = r_product;

endmodule

// File: tb/tb_seq_signed_shift_add_multiplier.sv
module tb_seq_signed_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Lane 0: WIDTH=4, lane 1: WIDTH=8, lane 2: WIDTH=16
  logic        tb_start[3] = '{1'b0, 1'b0, 1'b0};
  logic        tb_sm[3]    = '{1'b0, 1'b0, 1'b0};
  logic [31:0] tb_a[3]     = '{32'd0, 32'd0, 32'd0};
  logic [31:0] tb_b[3]     = '{32'd0, 32'd0, 32'd0};
  logic        obs_busy[3];
  logic        obs_done[3];
  logic [31:0] obs_product[3];

  seq_signed_shift_add_multiplier_if #(.WIDTH(4))  if4 ();
  seq_signed_shift_add_multiplier_if #(.WIDTH(8))  if8 ();
  seq_signed_shift_add_multiplier_if #(.WIDTH(16)) if16 ();

  seq_signed_shift_add_multiplier #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_signed_shift_add_multiplier #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  seq_signed_shift_add_multiplier #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  assign if4.i_start        = tb_start[0];
  assign if4.i_signed_mode  = tb_sm[0];
  assign if4.i_a            = tb_a[0][3:0];
  assign if4.i_b            = tb_b[0][3:0];
  assign if8.i_start        = tb_start[1];
  assign if8.i_signed_mode  = tb_sm[1];
  assign if8.i_a            = tb_a[1][7:0];
  assign if8.i_b            = tb_b[1][7:0];
  assign if16.i_start       = tb_start[2];
  assign if16.i_signed_mode = tb_sm[2];
  assign if16.i_a           = tb_a[2][15:0];
  assign if16.i_b           = tb_b[2][15:0];

  assign obs_busy[0]    = if4.o_busy;
  assign obs_done[0]    = if4.o_done;
  assign obs_product[0] = {24'd0, if4.o_product};
  assign obs_busy[1]    = if8.o_busy;
  assign obs_done[1]    = if8.o_done;
  assign obs_product[1] = {16'd0, if8.o_product};
  assign obs_busy[2]    = if16.o_busy;
  assign obs_done[2]    = if16.o_done;
  assign obs_product[2] = if16.o_product;

  int checks = 0;
  int errors = 0;
  int ndone[3] = '{0, 0, 0};

  function automatic int w_of(int l);
    return (l == 0) ? 4 : (l == 1) ? 8 : 16;
  endfunction

  // Reference: exact integer product of the operands as interpreted by mode,
  // reduced to 2*w bits.
  function automatic logic [31:0] ref_mul(int w, logic sm, logic [31:0] a, logic [31:0] b);
    longint m, x, y, p;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (sm && x[w-1]) x = x - (longint'(1) << w);
    if (sm && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a lane is busy for WIDTH+2 cycles after an
  // accepted start, pulses done in the last of them, and then publishes the
  // exact product, which it holds until the next result.
  int          m_left[3] = '{0, 0, 0};
  logic [31:0] m_exp[3]  = '{32'd0, 32'd0, 32'd0};
  logic [31:0] m_held[3] = '{32'd0, 32'd0, 32'd0};

  always @(posedge clk or posedge rst) begin
    for (int l = 0; l < 3; l++) begin
      if (rst) begin
        m_left[l] <= 0;
        m_held[l] <= '0;
      end else if (m_left[l] == 0) begin
        if (tb_start[l]) begin
          m_left[l] <= w_of(l) + 2;
          m_exp[l]  <= ref_mul(w_of(l), tb_sm[l], tb_a[l], tb_b[l]);
        end
      end else begin
        m_left[l] <= m_left[l] - 1;
        if (m_left[l] == 2) m_held[l] <= m_exp[l];
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("busy_w%0d", w_of(l)), 32'(obs_busy[l]), 32'(m_left[l] != 0));
      chk($sformatf("done_w%0d", w_of(l)), 32'(obs_done[l]), 32'(m_left[l] == 1));
      chk($sformatf("product_w%0d", w_of(l)), obs_product[l], m_held[l]);
      if (obs_done[l]) ndone[l] = ndone[l] + 1;
    end
  end

  task automatic wait_idle(int l);
    bit ok;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!obs_busy[l]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(int l, output logic [31:0] prod, output int lat);
    lat  = -1;
    prod = '0;
    for (int n = 1; n <= w_of(l) + 8; n++) begin
      @(negedge clk);
      if (obs_done[l]) begin
        lat  = n;
        prod = obs_product[l];
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Start one operation; operands are scrambled right after acceptance to
  // show they are not re-sampled while busy.
  task automatic run_op(int l, logic sm, logic [31:0] a, logic [31:0] b,
                        output logic [31:0] prod, output int lat);
    wait_idle(l);
    #1;
    tb_a[l] = a; tb_b[l] = b; tb_sm[l] = sm; tb_start[l] = 1'b1;
    @(negedge clk);
    #1;
    tb_start[l] = 1'b0;
    tb_a[l] = $urandom; tb_b[l] = $urandom; tb_sm[l] = 1'($urandom);
    wait_done(l, prod, lat);
  endtask

  task automatic rand_lane(int l);
    logic [31:0] p, a, b, mask;
    logic        sm;
    int          lat, sel;
    mask = 32'((longint'(1) << w_of(l)) - 1);
    repeat (1000) begin
      sm  = 1'($urandom);
      a   = $urandom & mask;
      b   = $urandom & mask;
      sel = $urandom_range(0, 7);
      if (sel == 0) a = mask;
      if (sel == 1) b = 32'(1) << (w_of(l) - 1);
      if (sel == 2) a = 0;
      run_op(l, sm, a, b, p, lat);
      chk($sformatf("rand_latency_w%0d", w_of(l)), 32'(lat), 32'(w_of(l) + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    int lat, n0, acc;
    logic prevb;

    chk("model_pin_m3x5", ref_mul(4, 1'b1, 32'hD, 32'h5), 32'hF1);
    chk("model_pin_m1xm1_w16", ref_mul(16, 1'b1, 32'hFFFF, 32'hFFFF), 32'h1);
    chk("model_pin_u255sq", ref_mul(8, 1'b0, 32'hFF, 32'hFF), 32'hFE01);

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(obs_busy[1]), 32'd0);
    chk("reset_product", obs_product[1], 32'd0);
    #1 rst = 1'b0;

    run_op(0, 1'b1, 32'hD, 32'h5, p, lat);
    chk("w4_m3x5", p, 32'hF1);
    chk("w4_m3x5_latency", 32'(lat), 32'd5);
    run_op(0, 1'b1, 32'h8, 32'h7, p, lat);
    chk("w4_s_8x7", p, 32'hC8);
    run_op(0, 1'b0, 32'h8, 32'h7, p, lat);
    chk("w4_u_8x7", p, 32'h38);

    run_op(1, 1'b1, 32'h80, 32'h80, p, lat);
    chk("w8_m128sq", p, 32'h4000);
    run_op(1, 1'b1, 32'h7F, 32'hFF, p, lat);
    chk("w8_127xm1", p, 32'hFF81);
    run_op(1, 1'b1, 32'h00, 32'hB3, p, lat);
    chk("w8_0xm77", p, 32'h0000);
    run_op(1, 1'b0, 32'hFF, 32'hFF, p, lat);
    chk("w8_u255sq", p, 32'hFE01);

    // Start and new operands during RUN must be ignored.
    wait_idle(1);
    #1 tb_a[1] = 32'hF6; tb_b[1] = 32'h0D; tb_sm[1] = 1'b1; tb_start[1] = 1'b1;
    @(negedge clk);
    #1 tb_start[1] = 1'b0;
    @(negedge clk);
    #1 tb_a[1] = 32'h01; tb_b[1] = 32'h02; tb_sm[1] = 1'b0; tb_start[1] = 1'b1;
    @(negedge clk);
    #1 tb_start[1] = 1'b0;
    wait_done(1, p, lat);
    chk("w8_ignore_start_in_run", p, 32'hFF7E);

    // Start held high: three back-to-back operations, one done each.
    wait_idle(0);
    n0 = ndone[0];
    acc = 0;
    prevb = 1'b0;
    #1 tb_a[0] = $urandom; tb_b[0] = $urandom; tb_sm[0] = 1'($urandom); tb_start[0] = 1'b1;
    for (int n = 0; n < 60 && acc < 3; n++) begin
      @(negedge clk);
      if (obs_busy[0] && !prevb) begin
        acc++;
        #1 tb_a[0] = $urandom; tb_b[0] = $urandom; tb_sm[0] = 1'($urandom);
        if (acc == 3) tb_start[0] = 1'b0;
      end
      prevb = obs_busy[0];
    end
    repeat (8) @(negedge clk);
    chk("held_start_accepts", 32'(acc), 32'd3);
    chk("held_start_dones", 32'(ndone[0] - n0), 32'd3);

    // Reset at count=3 of an 8-bit operation.
    wait_idle(1);
    #1 tb_a[1] = 32'h5A; tb_b[1] = 32'h3C; tb_sm[1] = 1'b1; tb_start[1] = 1'b1;
    @(negedge clk);
    #1 tb_start[1] = 1'b0;
    repeat (3) @(negedge clk);
    n0 = ndone[1];
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(obs_busy[1]), 32'd0);
    chk("async_rst_done", 32'(obs_done[1]), 32'd0);
    chk("async_rst_product", obs_product[1], 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (14) @(negedge clk);
    chk("no_done_after_abort", 32'(ndone[1] - n0), 32'd0);
    run_op(1, 1'b1, 32'h5A, 32'h3C, p, lat);
    chk("w8_after_reset", p, 32'h1518);

    fork
      rand_lane(0);
      rand_lane(1);
      rand_lane(2);
    join
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
